result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the entries per bank FIFO (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port srstn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port tpu_done, input, 1 bit: end-of-computation pulse from the TPU core.
REQ-005 SHALL have ports sram_write_enable_a0/b0/c0, input, 1 bit each: result-bank write strobes, active-low.
REQ-006 SHALL have ports sram_wdata_a/b/c, input, 128 bits each: result words.
REQ-007 SHALL have ports sram_waddr_a/b/c, input, 6 bits each: result-bank addresses.
REQ-008 SHALL have port out_valid, output, 1 bit: host beat valid.
REQ-009 SHALL have port out_ready, input, 1 bit: host beat accept.
REQ-010 SHALL have port out_data, output, 32 bits: beat payload.
REQ-011 SHALL have port out_tag, output, 10 bits: {bank[1:0] (a=0, b=1, c=2), addr[5:0], beat[1:0]}.
REQ-012 SHALL have port drain_done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port overflow, output, 1 bit: sticky drop flag.

Function
REQ-014 SHALL push {waddr, wdata} into bank x's FIFO on every edge where sram_write_enable_x0 is 0; all three banks may push in the same cycle.
REQ-015 SHALL drop the word and set overflow (sticky until reset) when a push targets a full FIFO and that FIFO does not pop in the same cycle.
REQ-016 SHALL accept a push to a full FIFO without overflow when the same FIFO pops in that cycle.
REQ-017 SHALL use an FSM with states IDLE, SEND, DONE.
REQ-018 SHALL, in IDLE, pick the first non-empty FIFO in round-robin order (starting with the bank after the last one served; a first after reset), pop it and enter SEND with beat counter 0.
REQ-019 SHALL, in SEND, drive out_valid=1, out_data=word[32*beat+31 : 32*beat], out_tag per REQ-011; beat 0 is bits [31:0].
REQ-020 SHALL advance the beat only on out_valid && out_ready, holding out_data and out_tag stable otherwise.
REQ-021 SHALL, after beat 3 is accepted, return to IDLE; a back-to-back word may start on the next edge.
REQ-022 SHALL raise out_valid on the second rising edge after the edge that sampled a write into an empty FIFO while the FSM is idle (latency 2).
REQ-023 SHALL latch tpu_done; when the latch is set, all FIFOs are empty and the FSM is in IDLE, it SHALL enter DONE, pulse drain_done for exactly one cycle, clear the latch and return to IDLE.
REQ-024 SHALL give writes that arrive in the same cycle as the DONE decision the normal path; they are not lost.

Reset
REQ-025 SHALL, on srstn=0, immediately clear all FIFOs, the round-robin pointer, the tpu_done latch and overflow, force the FSM to IDLE, and drive out_valid=0, out_data=0, out_tag=0, drain_done=0, asynchronously.
REQ-026 SHALL discard any partially sent word on reset mid-operation; no beat of it resumes afterwards.

Structure
REQ-027 SHALL place the bank-ID encoding, the FSM state type, and the word/tag widths (128, 32, 6, 10) in the shared TPU package.
REQ-028 SHALL implement each bank FIFO as one sub-module, drain_fifo, instantiated three times.

Verification
REQ-029 SHALL test a single write: b0=0, waddr_b=5, wdata_b=128'h0123..CDEF, out_ready=1 -> out_valid rises 2 edges later; 4 beats with tags {1,5,0..3}; out_data starts at bits [31:0].
REQ-030 SHALL test simultaneous writes: a, b and c written in one cycle -> beats emitted in order a, b, c (12 beats), no overflow.
REQ-031 SHALL test backpressure: out_ready=0 for 10 cycles mid-word -> out_data and out_tag held constant, no beat skipped or repeated.
REQ-032 SHALL test overflow: 5 writes to bank a with out_ready=0 and FIFO_DEPTH=4 -> overflow=1, exactly 4 a-words drained afterwards.
REQ-033 SHALL test completion: tpu_done pulses while 2 words are queued -> drain_done pulses once, only after the last beat is accepted.
REQ-034 SHALL test reset mid-operation: srstn=0 during beat 2 -> out_valid=0 immediately, and after release no output until a new write.

Source files
------------

// File: rtl/result_drain_pkg.sv
// result_drain_pkg: shared definitions for the TPU result drain.
//   - word/beat/address/tag widths
//   - bank ID encoding (a=0, b=1, c=2)
//   - drain FSM state type
//   - FIFO entry layout {addr, data}
package result_drain_pkg;

  localparam int WORD_W    = 128;
  localparam int BEAT_W    = 32;
  localparam int ADDR_W    = 6;
  localparam int TAG_W     = 10;
  localparam int NUM_BANKS = 3;

  typedef enum logic [1:0] {
    BANK_A = 2'd0,
    BANK_B = 2'd1,
    BANK_C = 2'd2
  } bank_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Round-robin successor over the three banks.
  function automatic logic [1:0] next_bank(input logic [1:0] b);
    return (b == BANK_C) ? BANK_A : 2'(b + 2'd1);
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: per-bank result FIFO.
//   clk, srstn      : clock, async active-low reset (clears pointers/count)
//   push, push_data : write request and {addr, data} entry
//   pop             : remove head (ignored when empty)
//   head            : current head entry (valid when !empty)
//   empty           : no entries held
//   drop            : push hit a full FIFO that is not popping this cycle
module drain_fifo
  import result_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   srstn,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rptr];

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// result_drain: buffers result-bank writes (a/b/c) in per-bank FIFOs and
// streams each 128-bit word to the host as four 32-bit beats.
//   clk, srstn                  : clock, async active-low reset
//   tpu_done                    : end-of-computation pulse (latched)
//   sram_write_enable_{a,b,c}0  : active-low bank write strobes
//   sram_wdata_{a,b,c}          : 128-bit result words
//   sram_waddr_{a,b,c}          : 6-bit bank addresses
//   out_valid/out_ready         : host beat handshake
//   out_data                    : beat payload, beat 0 = word[31:0]
//   out_tag                     : {bank[1:0], addr[5:0], beat[1:0]}
//   drain_done                  : one-cycle pulse once tpu_done seen and all drained
//   overflow                    : sticky, a write was dropped on a full FIFO
module result_drain
  import result_drain_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              tpu_done,
  input  logic              sram_write_enable_a0,
  input  logic              sram_write_enable_b0,
  input  logic              sram_write_enable_c0,
  input  logic [WORD_W-1:0] sram_wdata_a,
  input  logic [WORD_W-1:0] sram_wdata_b,
  input  logic [WORD_W-1:0] sram_wdata_c,
  input  logic [ADDR_W-1:0] sram_waddr_a,
  input  logic [ADDR_W-1:0] sram_waddr_b,
  input  logic [ADDR_W-1:0] sram_waddr_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              drain_done,
  output logic              overflow
);

  logic [NUM_BANKS-1:0] push, pop, empty, drop;
  entry_t               push_d [NUM_BANKS];
  entry_t               head   [NUM_BANKS];

  assign push      = ~{sram_write_enable_c0, sram_write_enable_b0, sram_write_enable_a0};
  assign push_d[0] = '{addr: sram_waddr_a, data: sram_wdata_a};
  assign push_d[1] = '{addr: sram_waddr_b, data: sram_wdata_b};
  assign push_d[2] = '{addr: sram_waddr_c, data: sram_wdata_c};

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    drain_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .srstn     (srstn),
      .push      (push[g]),
      .push_data (push_d[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .empty     (empty[g]),
      .drop      (drop[g])
    );
  end

  state_e            state;
  logic [1:0]        rr_ptr;     // bank to try first
  logic              done_pend;  // tpu_done seen, drain not yet reported
  entry_t            word_q;
  logic [1:0]        bank_q;
  logic [1:0]        beat, beat_nxt;
  logic              sel_vld;
  logic [1:0]        sel_idx;
  entry_t            sel_head;

  // First non-empty bank scanning from rr_ptr.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = rr_ptr;
    for (int i = 0; i < NUM_BANKS; i++) begin
      int k;
      k = (int'(rr_ptr) + i) % NUM_BANKS;
      if (!sel_vld && !empty[k]) begin
        sel_vld = 1'b1;
        sel_idx = 2'(k);
      end
    end
  end

  always_comb begin
    case (sel_idx)
      2'd0:    sel_head = head[0];
      2'd1:    sel_head = head[1];
      default: sel_head = head[2];
    endcase
  end

  assign pop      = (state == S_IDLE && sel_vld) ? 3'(3'b001 << sel_idx) : '0;
  assign beat_nxt = beat + 2'd1;

  // Entering SEND latches the word; the first beat is presented one edge
  // later, giving a two-edge write-to-valid latency from an idle drain.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state      <= S_IDLE;
      rr_ptr     <= BANK_A;
      done_pend  <= 1'b0;
      word_q     <= '0;
      bank_q     <= '0;
      beat       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      drain_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow   <= overflow | (|drop);
      done_pend  <= done_pend | tpu_done;
      drain_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            word_q <= sel_head;
            bank_q <= sel_idx;
            beat   <= '0;
            rr_ptr <= next_bank(sel_idx);
            state  <= S_SEND;
          end else if (done_pend) begin
            // All FIFOs empty here; a fresh tpu_done this cycle stays latched.
            drain_done <= 1'b1;
            done_pend  <= tpu_done;
            state      <= S_DONE;
          end
        end
        S_SEND: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= word_q.data[BEAT_W*beat +: BEAT_W];
            out_tag   <= {bank_q, word_q.addr, beat};
          end else if (out_ready) begin
            if (beat == 2'd3) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_tag   <= '0;
              state     <= S_IDLE;
            end else begin
              beat     <= beat_nxt;
              out_data <= word_q.data[BEAT_W*beat_nxt +: BEAT_W];
              out_tag  <= {bank_q, word_q.addr, beat_nxt};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

  logic         clk = 1'b0;
  logic         srstn;
  logic         tpu_done;
  logic         we_a, we_b, we_c;
  logic [127:0] wd_a, wd_b, wd_c;
  logic [5:0]   wa_a, wa_b, wa_c;
  logic         out_valid, out_ready, drain_done, overflow;
  logic [31:0]  out_data;
  logic [9:0]   out_tag;

  always #5 clk = ~clk;

  result_drain #(.FIFO_DEPTH(4)) dut (
    .clk                  (clk),
    .srstn                (srstn),
    .tpu_done             (tpu_done),
    .sram_write_enable_a0 (we_a),
    .sram_write_enable_b0 (we_b),
    .sram_write_enable_c0 (we_c),
    .sram_wdata_a         (wd_a),
    .sram_wdata_b         (wd_b),
    .sram_wdata_c         (wd_c),
    .sram_waddr_a         (wa_a),
    .sram_waddr_b         (wa_b),
    .sram_waddr_c         (wa_c),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_tag              (out_tag),
    .drain_done           (drain_done),
    .overflow             (overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic [9:0]  tag;
  } beat_t;

  typedef struct {
    logic [1:0]   bank;
    logic [5:0]   addr;
    logic [127:0] data;
    logic [31:0]  exp_b0;
    logic [9:0]   exp_tag0;
  } vec_t;

  beat_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [1:0] bank, input logic [5:0] addr, input logic [127:0] d);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.data = d[32*b +: 32];
      e.tag  = {bank, addr, 2'(b)};
      sb.push_back(e);
    end
  endtask

  task automatic set_wr(input logic [1:0] bank, input logic [5:0] addr, input logic [127:0] d);
    case (bank)
      2'd0:    begin we_a = 1'b0; wa_a = addr; wd_a = d; end
      2'd1:    begin we_b = 1'b0; wa_b = addr; wd_b = d; end
      default: begin we_c = 1'b0; wa_c = addr; wd_c = d; end
    endcase
  endtask

  task automatic clr_wr();
    we_a = 1'b1; we_b = 1'b1; we_c = 1'b1;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain timeout", 128'(sb.size()), 128'd0);
    repeat (4) tick();
  endtask

  // Scoreboard monitor: a beat is taken at the next rising edge when
  // valid && ready are both seen here (inputs only change just after posedge).
  always @(negedge clk) begin
    if (srstn) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected beat: got data %0h tag %0h, none expected", out_data, out_tag);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat data", 128'(out_data), 128'(e.data));
          chk("beat tag", 128'(out_tag), 128'(e.tag));
        end
      end
      if (drain_done) begin
        done_cnt++;
        chk("drain_done before last beat", 128'(sb.size()), 128'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t         vt [4];
    logic [127:0] d, da, db, dc;
    int           dc0;

    vt[0] = '{2'd1, 6'd5,  128'h0123456789ABCDEF0123456789ABCDEF, 32'h89ABCDEF, 10'h114};
    vt[1] = '{2'd0, 6'd63, 128'h00000004000000030000000200000001, 32'h00000001, 10'h0FC};
    vt[2] = '{2'd2, 6'd0,  128'hDEADBEEFCAFEF00D12345678A5A5A5A5, 32'hA5A5A5A5, 10'h200};
    vt[3] = '{2'd2, 6'd42, 128'h11112222333344445555666677778888, 32'h77778888, 10'h2A8};

    srstn = 1'b0; tpu_done = 1'b0; out_ready = 1'b0;
    wd_a = '0; wd_b = '0; wd_c = '0; wa_a = '0; wa_b = '0; wa_c = '0;
    clr_wr();
    #12;
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset out_data", 128'(out_data), 128'd0);
    chk("reset out_tag", 128'(out_tag), 128'd0);
    chk("reset drain_done", 128'(drain_done), 128'd0);
    chk("reset overflow", 128'(overflow), 128'd0);
    @(posedge clk); #1 srstn = 1'b1;
    tick();

    // Simultaneous writes to a, b, c: served a, b, c.
    out_ready = 1'b1;
    da = 128'hA0000003A0000002A0000001A0000000;
    db = 128'hB0000003B0000002B0000001B0000000;
    dc = 128'hC0000003C0000002C0000001C0000000;
    set_wr(2'd0, 6'd1, da); set_wr(2'd1, 6'd2, db); set_wr(2'd2, 6'd3, dc);
    exp_word(2'd0, 6'd1, da); exp_word(2'd1, 6'd2, db); exp_word(2'd2, 6'd3, dc);
    tick(); clr_wr();
    wait_empty(100);
    chk("simul overflow", 128'(overflow), 128'd0);

    // Single-write table: latency and first beat.
    for (int i = 0; i < 4; i++) begin
      set_wr(vt[i].bank, vt[i].addr, vt[i].data);
      exp_word(vt[i].bank, vt[i].addr, vt[i].data);
      tick(); clr_wr();
      chk("latency edge1 valid", 128'(out_valid), 128'd0);
      tick();
      chk("latency edge2 valid", 128'(out_valid), 128'd0);
      tick();
      chk("latency edge3 valid", 128'(out_valid), 128'd1);
      chk("first beat data", 128'(out_data), 128'(vt[i].exp_b0));
      chk("first beat tag", 128'(out_tag), 128'(vt[i].exp_tag0));
      wait_empty(50);
    end

    // Backpressure during beat 2.
    d = 128'h44444444333333332222222211111111;
    set_wr(2'd0, 6'd9, d);
    exp_word(2'd0, 6'd9, d);
    tick(); clr_wr();
    repeat (4) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold valid", 128'(out_valid), 128'd1);
      chk("hold data", 128'(out_data), 128'(d[95:64]));
      chk("hold tag", 128'(out_tag), 128'({2'd0, 6'd9, 2'd2}));
      tick();
    end
    out_ready = 1'b1;
    wait_empty(50);

    // Overflow: b stalls the drain, then 5 writes to a; the fifth is dropped.
    out_ready = 1'b0;
    d = 128'hBBBB0003BBBB0002BBBB0001BBBB0000;
    set_wr(2'd1, 6'd7, d);
    exp_word(2'd1, 6'd7, d);
    tick(); clr_wr();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      d = {32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)};
      set_wr(2'd0, 6'(10 + i), d);
      if (i < 4) exp_word(2'd0, 6'(10 + i), d);
      tick();
      if (i == 3) chk("overflow before drop", 128'(overflow), 128'd0);
    end
    clr_wr();
    chk("overflow after drop", 128'(overflow), 128'd1);
    out_ready = 1'b1;
    wait_empty(200);
    chk("overflow sticky", 128'(overflow), 128'd1);

    // Completion: tpu_done while two words are queued.
    out_ready = 1'b0;
    dc0 = done_cnt;
    d = 128'hC1C1C1C4C1C1C1C3C1C1C1C2C1C1C1C1;
    set_wr(2'd2, 6'd20, d); exp_word(2'd2, 6'd20, d);
    tick();
    d = 128'hC2C2C2C4C2C2C2C3C2C2C2C2C2C2C2C1;
    set_wr(2'd2, 6'd21, d); exp_word(2'd2, 6'd21, d);
    tick(); clr_wr();
    tpu_done = 1'b1;
    tick();
    tpu_done = 1'b0;
    repeat (5) tick();
    chk("no early drain_done", 128'(done_cnt - dc0), 128'd0);
    out_ready = 1'b1;
    wait_empty(100);
    chk("drain_done once", 128'(done_cnt - dc0), 128'd1);

    // Reset while beat 2 is on the bus.
    d = 128'h9999000399990002999900019999000;
    set_wr(2'd0, 6'd30, d);
    exp_word(2'd0, 6'd30, d);
    tick(); clr_wr();
    repeat (4) tick();
    #2 srstn = 1'b0;
    #1;
    chk("async reset valid", 128'(out_valid), 128'd0);
    chk("async reset data", 128'(out_data), 128'd0);
    chk("async reset tag", 128'(out_tag), 128'd0);
    chk("async reset overflow", 128'(overflow), 128'd0);
    sb.delete();
    @(posedge clk); #1 srstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) chk("idle after reset", 128'(out_valid), 128'd0);
    end

    // Round-robin restarts at a after reset.
    da = 128'hAAAA0003AAAA0002AAAA0001AAAA0000;
    dc = 128'hCCCC0003CCCC0002CCCC0001CCCC0000;
    set_wr(2'd2, 6'd33, dc); set_wr(2'd0, 6'd32, da);
    exp_word(2'd0, 6'd32, da); exp_word(2'd2, 6'd33, dc);
    tick(); clr_wr();
    wait_empty(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
